// File: rtl/shifter_pkg.sv
// shifter_pkg: mode and state encodings shared by the shamt_shifter slice.
package shifter_pkg;
    typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_ROR = 2'b11} mode_e;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_DONE = 2'b10} state_e;
endpackage

// File: rtl/shamt_select.sv
// shamt_select: picks the shift amount from the shamt field or the low bits of a register operand.
module shamt_select #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               amt_src,
    input  logic [SHAMT_W-1:0] shamt_imm,
    input  logic [DATA_W-1:0]  amt_reg,
    output logic [SHAMT_W-1:0] amt
);
    logic unused_hi;
    assign unused_hi = ^amt_reg[DATA_W-1:SHAMT_W];
    assign amt = amt_src ? amt_reg[SHAMT_W-1:0] : shamt_imm;
endmodule

// File: rtl/shamt_shifter.sv
// shamt_shifter: one-bit-per-cycle shift unit; SHAMT_SHIFTER_ROTATE_EN enables mode 11 (ROR).
module shamt_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               amt_src,
    input  logic [SHAMT_W-1:0] shamt_imm,
    input  logic [DATA_W-1:0]  amt_reg,
    input  logic [DATA_W-1:0]  din,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [DATA_W-1:0]  result
);
    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [DATA_W-1:0]   data_q, data_d, result_q, result_d, shifted;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d, amt_sel, amt_eff;
    logic                fill;

    shamt_select #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_sel (
        .amt_src   (amt_src),
        .shamt_imm (shamt_imm),
        .amt_reg   (amt_reg),
        .amt       (amt_sel)
    );

`ifdef SHAMT_SHIFTER_ROTATE_EN
    assign amt_eff = amt_sel;
    assign fill    = (mode_q == SH_ROR) ? data_q[0] : (mode_q == SH_SRA) & data_q[DATA_W-1];
`else
    // Unsupported rotate completes immediately as a zero-length pass-through.
    assign amt_eff = (mode == SH_ROR) ? '0 : amt_sel;
    assign fill    = (mode_q == SH_SRA) & data_q[DATA_W-1];
`endif
    assign shifted = (mode_q == SH_SLL) ? {data_q[DATA_W-2:0], 1'b0} : {fill, data_q[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= SH_SLL;
            data_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // result is loaded on entry to DONE so it is already valid while done is high.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        data_d   = data_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: if (start) begin
                data_d   = din;
                mode_d   = mode_e'(mode);
                cnt_d    = amt_eff;
                state_d  = (amt_eff == '0) ? ST_DONE : ST_SHIFT;
                result_d = (amt_eff == '0) ? din : result_q;
            end
            ST_SHIFT: begin
                data_d   = shifted;
                cnt_d    = cnt_q - SHAMT_W'(1);
                state_d  = (cnt_q == SHAMT_W'(1)) ? ST_DONE : ST_SHIFT;
                result_d = (cnt_q == SHAMT_W'(1)) ? shifted : result_q;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = state_q != ST_IDLE;
        done    = state_q == ST_DONE;
`ifdef SHAMT_SHIFTER_ROTATE_EN
        illegal = 1'b0;
`else
        illegal = done && mode_q == SH_ROR;
`endif
        result  = result_q;
    end
endmodule
